// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with optional auto-reload and a one-cycle expiry pulse.
// busy/expired decode the registered state; load_ready is the only path from an input (abort).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             expired
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             ready_en;

  // ready_en keeps load_ready low through reset and until the first edge after release.
  assign load_ready = ready_en && (state == IDLE) && !abort;
  assign busy       = (state == RUN);
  assign expired    = (state == EXPIRE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      reload   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            cnt    <= load_value;
            reload <= load_value;
            state  <= (load_value != '0) ? RUN : EXPIRE;
          end
        end
        RUN: begin
          if (abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (enable && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
            if (cnt == WIDTH'(1)) begin
              state <= EXPIRE;
            end
          end
        end
        EXPIRE: begin
          // abort lets this pulse finish but cancels any reload.
          if (AUTO_RELOAD && !abort && (reload != '0)) begin
            cnt   <= reload;
            state <= RUN;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one plain instance and one with auto-reload.
module tb_countdown_timer;

  logic       clk;
  logic       reset_n;

  logic       load_valid;
  logic [7:0] load_value;
  logic       load_ready;
  logic       enable;
  logic       abort;
  logic [7:0] cnt;
  logic       busy;
  logic       expired;

  logic       a_load_valid;
  logic [7:0] a_load_value;
  logic       a_load_ready;
  logic       a_enable;
  logic       a_abort;
  logic [7:0] a_cnt;
  logic       a_busy;
  logic       a_expired;

  int n_cmp = 0;
  int n_err = 0;

  countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .enable     (enable),
    .abort      (abort),
    .cnt        (cnt),
    .busy       (busy),
    .expired    (expired)
  );

  countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (a_load_valid),
    .load_value (a_load_value),
    .load_ready (a_load_ready),
    .enable     (a_enable),
    .abort      (a_abort),
    .cnt        (a_cnt),
    .busy       (a_busy),
    .expired    (a_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tog_en  [6];
    logic [7:0] tog_cnt [6];
    logic       tog_exp [6];
    logic [7:0] ar_cnt  [7];
    logic       ar_exp  [7];

    tog_en  = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    tog_cnt = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    tog_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ar_cnt  = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
    ar_exp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n      = 1'b0;
    load_valid   = 1'b0;
    load_value   = 8'd0;
    enable       = 1'b0;
    abort        = 1'b0;
    a_load_valid = 1'b0;
    a_load_value = 8'd0;
    a_enable     = 1'b0;
    a_abort      = 1'b0;

    // Reset values and load_ready held low across reset and until the first edge.
    #3;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_expired", 32'(expired), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    #19;
    reset_n = 1'b1;
    #1;
    chk("post_release_ready_before_edge", 32'(load_ready), 32'd0);
    step();
    chk("ready_after_first_edge", 32'(load_ready), 32'd1);

    // Load 5, enable high: 5,4,3,2,1,0 and a single expiry pulse.
    load_valid = 1'b1;
    load_value = 8'd5;
    enable     = 1'b1;
    step();
    load_valid = 1'b0;
    chk("l5_accept_cnt", 32'(cnt), 32'd5);
    chk("l5_accept_busy", 32'(busy), 32'd1);
    chk("l5_accept_ready", 32'(load_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("l5_cnt", 32'(cnt), 32'(5 - k));
      chk("l5_expired", 32'(expired), (k == 5) ? 32'd1 : 32'd0);
      chk("l5_busy", 32'(busy), (k == 5) ? 32'd0 : 32'd1);
    end
    step();
    chk("l5_idle_expired", 32'(expired), 32'd0);
    chk("l5_idle_ready", 32'(load_ready), 32'd1);
    chk("l5_idle_cnt", 32'(cnt), 32'd0);

    // Load 4 with enable gaps: count holds while enable is low.
    load_valid = 1'b1;
    load_value = 8'd4;
    step();
    load_valid = 1'b0;
    chk("l4_accept_cnt", 32'(cnt), 32'd4);
    for (int k = 0; k < 6; k++) begin
      enable = tog_en[k][0];
      step();
      chk("l4_cnt", 32'(cnt), 32'(tog_cnt[k]));
      chk("l4_expired", 32'(expired), 32'(tog_exp[k]));
    end
    step();
    chk("l4_done_expired", 32'(expired), 32'd0);
    chk("l4_done_busy", 32'(busy), 32'd0);

    // Load 0: expires straight away, never busy.
    load_valid = 1'b1;
    load_value = 8'd0;
    step();
    load_valid = 1'b0;
    chk("l0_expired", 32'(expired), 32'd1);
    chk("l0_busy", 32'(busy), 32'd0);
    chk("l0_cnt", 32'(cnt), 32'd0);
    step();
    chk("l0_after_expired", 32'(expired), 32'd0);
    chk("l0_after_busy", 32'(busy), 32'd0);
    chk("l0_after_ready", 32'(load_ready), 32'd1);

    // Load 200, abort at 100, then a load attempt blocked by abort.
    load_valid = 1'b1;
    load_value = 8'd200;
    enable     = 1'b1;
    step();
    load_valid = 1'b0;
    chk("l200_accept_cnt", 32'(cnt), 32'd200);
    repeat (100) step();
    chk("l200_mid_cnt", 32'(cnt), 32'd100);
    abort = 1'b1;
    #1;
    chk("abort_blocks_ready_run", 32'(load_ready), 32'd0);
    step();
    chk("abort_cnt", 32'(cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_expired", 32'(expired), 32'd0);
    chk("abort_idle_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_value = 8'd9;
    step();
    chk("abort_load_cnt", 32'(cnt), 32'd0);
    chk("abort_load_busy", 32'(busy), 32'd0);
    step();
    chk("abort_load_expired", 32'(expired), 32'd0);
    load_valid = 1'b0;
    abort      = 1'b0;
    #1;
    chk("abort_released_ready", 32'(load_ready), 32'd1);

    // Asynchronous reset mid-count at 7.
    load_valid = 1'b1;
    load_value = 8'd10;
    step();
    load_valid = 1'b0;
    repeat (3) step();
    chk("ar_mid_cnt", 32'(cnt), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_expired", 32'(expired), 32'd0);
    chk("async_rst_ready", 32'(load_ready), 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    chk("post_rst_expired", 32'(expired), 32'd0);
    chk("post_rst_cnt", 32'(cnt), 32'd0);

    // Auto-reload instance: load 3, repeated pulses, abort in EXPIRE ends it.
    a_load_valid = 1'b1;
    a_load_value = 8'd3;
    a_enable     = 1'b1;
    step();
    a_load_valid = 1'b0;
    chk("arl_accept_cnt", 32'(a_cnt), 32'd3);
    chk("arl_accept_busy", 32'(a_busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("arl_cnt", 32'(a_cnt), 32'(ar_cnt[k]));
      chk("arl_expired", 32'(a_expired), 32'(ar_exp[k]));
    end
    a_abort = 1'b1;
    #1;
    chk("arl_abort_pulse_held", 32'(a_expired), 32'd1);
    chk("arl_abort_ready", 32'(a_load_ready), 32'd0);
    step();
    chk("arl_abort_cnt", 32'(a_cnt), 32'd0);
    chk("arl_abort_expired", 32'(a_expired), 32'd0);
    chk("arl_abort_busy", 32'(a_busy), 32'd0);
    a_abort = 1'b0;
    step();
    chk("arl_idle_cnt", 32'(a_cnt), 32'd0);
    chk("arl_idle_busy", 32'(a_busy), 32'd0);
    chk("arl_idle_ready", 32'(a_load_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
